decodificador_comandos: RTL and testbench
=========================================

// Module: decodificador_comandos
// PURPOSE
//  Front-end sequencer for the lighting controller. Synchronizes push_button and infravermelho.
//  Classifies each button press by duration into one-cycle commands:
//   - short press: toggle lamp
//   - long press: toggle mode
//  Produces a debounced, hold-extended presence level from the IR sensor.
//  Sits between the board pins and the mode/lamp FSM, which consumes only these clean commands.
// PARAMETERS
//  DEBOUNCE_T        50    min consecutive high cycles for a valid press / IR detection
//  SWITCH_MODE_MIN_T 5300  press durations > this value are long (mode toggle); <= are short
//  PRESENCE_HOLD_T   3000  cycles presenca stays high after synced IR falls
// PORTS
//  clk                  in   1  single system clock, all logic on posedge
//  rst                  in   1  synchronous, active-high reset
//  push_button          in   1  raw button, asynchronous to clk
//  infravermelho        in   1  raw IR presence sensor, asynchronous to clk
//  cmd_alterna_lampada  out  1  one-cycle pulse: valid short press completed
//  cmd_alterna_modo     out  1  one-cycle pulse: valid long press completed
//  press_longo          out  1  level: button still held and duration already > SWITCH_MODE_MIN_T
//  presenca             out  1  level: debounced presence with off-delay
// BEHAVIOUR
//  - Reset: all outputs 0, FSMs idle, counters 0, sync flops 0.
//  - Reset mid-press/mid-hold aborts the operation with no pulse.
//  - Sync: each input passes a 2-FF synchronizer (b_s, ir_s); adds 2 cycles latency, preserves pulse length.
//  - Button FSM (estado_botao_t):
//    - OCIOSO: cnt=0; b_s=1 -> CONTANDO with cnt=1.
//    - CONTANDO: b_s=1 -> cnt++ saturating at SWITCH_MODE_MIN_T+1; b_s=0 -> DECIDE.
//    - DECIDE (1 cycle): N = cnt = number of consecutive b_s=1 cycles.
//      - N < DEBOUNCE_T: glitch, no pulse.
//      - DEBOUNCE_T <= N <= SWITCH_MODE_MIN_T: cmd_alterna_lampada.
//      - N > SWITCH_MODE_MIN_T: cmd_alterna_modo.
//      - Return to OCIOSO.
//  - Pulses are registered and high exactly 1 cycle, on the cycle after DECIDE. Both pulses are never high together.
//  - No release debounce: bounce on release yields sub-DEBOUNCE_T presses, which are discarded.
//  - Press starting in the first cycle after reset counts only post-reset cycles.
//  - press_longo rises the cycle cnt reaches SWITCH_MODE_MIN_T+1 while in CONTANDO; falls on entry to DECIDE.
//  - Counter width $clog2(SWITCH_MODE_MIN_T+2). Saturation means holds of any length never wrap into a short press.
//  - IR path (estado_ir_t):
//    - AUSENTE: ir_s=1 counts up; reaching DEBOUNCE_T consecutive -> PRESENTE, presenca=1. ir_s=0 clears count.
//    - PRESENTE: ir_s=0 -> SEGURANDO, hold timer loaded with PRESENCE_HOLD_T.
//    - SEGURANDO: timer decrements; ir_s=1 -> PRESENTE immediately (retrigger, no re-debounce, presenca stays 1);
//      timer hits 0 -> AUSENTE, presenca=0 on the next cycle.
//  - Button and IR paths are independent; simultaneous activity has no interaction.
// STRUCTURE
//  - Package pkg_controladora: estado_botao_t {OCIOSO,CONTANDO,DECIDE}, estado_ir_t {AUSENTE,PRESENTE,SEGURANDO},
//    default timing localparams shared with controladora.
//  - Sub-module sincronizador (2-FF, sync reset to 0), instantiated twice.
//  - Remainder is the two FSMs plus counters in this file.
// TESTING
//  1. Hold push_button 5300 cycles, release -> exactly one cmd_alterna_lampada pulse, cmd_alterna_modo stays 0,
//     press_longo never 1.
//  2. Hold push_button 5301 cycles -> press_longo rises while held, one cmd_alterna_modo pulse after release,
//     no lampada pulse.
//  3. Pulses of 49 cycles on push_button -> no command pulse.
//     Single 50-cycle press -> one cmd_alterna_lampada.
//  4. Hold 20000 cycles -> counter saturates, exactly one cmd_alterna_modo.
//  5. Assert rst for 3 cycles at cycle 3000 of a 6000-cycle press -> no pulse from the aborted press.
//     Remaining ~3000 post-reset cycles -> one cmd_alterna_lampada.
//  6. IR high 100 cycles then low -> presenca rises DEBOUNCE_T+2 cycles after IR rise, falls ~3000 cycles after ir_s falls.
//     Re-raising IR at hold cycle 1500 keeps presenca high continuously.

Source files
------------

// File: rtl/decodificador_comandos_pkg.sv
// Shared types and default timing for the lighting controller front-end
// and the mode/lamp controller that consumes its commands.
package pkg_controladora;

    // Button press classifier states
    typedef enum logic [1:0] {
        OCIOSO,
        CONTANDO,
        DECIDE
    } estado_botao_t;

    // IR presence states
    typedef enum logic [1:0] {
        AUSENTE,
        PRESENTE,
        SEGURANDO
    } estado_ir_t;

    // Default timing, in clk cycles
    localparam int DEBOUNCE_T_PADRAO        = 50;
    localparam int SWITCH_MODE_MIN_T_PADRAO = 5300;
    localparam int PRESENCE_HOLD_T_PADRAO   = 3000;

endpackage

// File: rtl/decodificador_comandos_if.sv
// Pin-side inputs and clean command outputs of the command decoder.
interface decodificador_comandos_if;

    logic push_button;
    logic infravermelho;
    logic cmd_alterna_lampada;
    logic cmd_alterna_modo;
    logic press_longo;
    logic presenca;

    // Board / stimulus side
    modport master (
        output push_button,
        output infravermelho,
        input  cmd_alterna_lampada,
        input  cmd_alterna_modo,
        input  press_longo,
        input  presenca
    );

    // Decoder side
    modport slave (
        input  push_button,
        input  infravermelho,
        output cmd_alterna_lampada,
        output cmd_alterna_modo,
        output press_longo,
        output presenca
    );

endinterface

// File: rtl/decodificador_comandos_sincronizador.sv
// Two-flop synchronizer for a single asynchronous input.
// Adds two cycles of latency and keeps pulse length intact.
module sincronizador (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/decodificador_comandos.sv
// Front-end for the lighting controller: classifies button presses into
// one-cycle lamp/mode toggle commands and turns the raw IR sensor into a
// debounced presence level with an off-delay.
module decodificador_comandos
    import pkg_controladora::*;
#(
    parameter int DEBOUNCE_T        = DEBOUNCE_T_PADRAO,
    parameter int SWITCH_MODE_MIN_T = SWITCH_MODE_MIN_T_PADRAO,
    parameter int PRESENCE_HOLD_T   = PRESENCE_HOLD_T_PADRAO
) (
    input  logic                     clk,
    input  logic                     rst,
    decodificador_comandos_if.slave  bus
);

    // Press counter saturates at SWITCH_MODE_MIN_T+1 so long holds never wrap
    localparam int CW = $clog2(SWITCH_MODE_MIN_T + 2);
    localparam int IW = $clog2(DEBOUNCE_T + 1);
    localparam int TW = $clog2(PRESENCE_HOLD_T + 1);

    localparam logic [CW-1:0] CNT_MAX   = CW'(SWITCH_MODE_MIN_T + 1);
    localparam logic [CW-1:0] CNT_LONGO = CW'(SWITCH_MODE_MIN_T);
    localparam logic [CW-1:0] CNT_DEB   = CW'(DEBOUNCE_T);
    localparam logic [IW-1:0] IR_ULTIMO = IW'(DEBOUNCE_T - 1);
    localparam logic [TW-1:0] HOLD_INI  = TW'(PRESENCE_HOLD_T);

    logic b_s;
    logic ir_s;

    sincronizador u_sync_botao (
        .clk (clk),
        .rst (rst),
        .d   (bus.push_button),
        .q   (b_s)
    );

    sincronizador u_sync_ir (
        .clk (clk),
        .rst (rst),
        .d   (bus.infravermelho),
        .q   (ir_s)
    );

    estado_botao_t   estado_botao;
    logic [CW-1:0]   cnt;
    logic            cmd_lampada;
    logic            cmd_modo;
    logic            longo;

    // Button FSM: count held cycles, classify on release, pulse one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_botao <= OCIOSO;
            cnt          <= '0;
            cmd_lampada  <= 1'b0;
            cmd_modo     <= 1'b0;
            longo        <= 1'b0;
        end else begin
            cmd_lampada <= 1'b0;
            cmd_modo    <= 1'b0;
            case (estado_botao)
                OCIOSO: begin
                    if (b_s) begin
                        estado_botao <= CONTANDO;
                        cnt          <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                CONTANDO: begin
                    if (b_s) begin
                        if (cnt != CNT_MAX)
                            cnt <= cnt + 1'b1;
                        // level goes high the cycle cnt becomes SWITCH_MODE_MIN_T+1
                        if (cnt >= CNT_LONGO)
                            longo <= 1'b1;
                    end else begin
                        estado_botao <= DECIDE;
                        longo        <= 1'b0;
                    end
                end
                DECIDE: begin
                    if (cnt > CNT_LONGO)
                        cmd_modo <= 1'b1;
                    else if (cnt >= CNT_DEB)
                        cmd_lampada <= 1'b1;
                    estado_botao <= OCIOSO;
                    cnt          <= '0;
                end
                default: begin
                    estado_botao <= OCIOSO;
                    cnt          <= '0;
                end
            endcase
        end
    end

    estado_ir_t      estado_ir;
    logic [IW-1:0]   ir_cnt;
    logic [TW-1:0]   hold;
    logic            presenca_q;

    // IR FSM: debounce rising presence, hold it after the sensor drops,
    // retrigger without re-debounce while holding
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_ir  <= AUSENTE;
            ir_cnt     <= '0;
            hold       <= '0;
            presenca_q <= 1'b0;
        end else begin
            case (estado_ir)
                AUSENTE: begin
                    if (ir_s) begin
                        if (ir_cnt == IR_ULTIMO) begin
                            estado_ir  <= PRESENTE;
                            presenca_q <= 1'b1;
                            ir_cnt     <= '0;
                        end else begin
                            ir_cnt <= ir_cnt + 1'b1;
                        end
                    end else begin
                        ir_cnt <= '0;
                    end
                end
                PRESENTE: begin
                    if (!ir_s) begin
                        estado_ir <= SEGURANDO;
                        hold      <= HOLD_INI;
                    end
                end
                SEGURANDO: begin
                    if (ir_s) begin
                        estado_ir <= PRESENTE;
                    end else if (hold == '0) begin
                        // timer reached zero last cycle; drop presence now
                        estado_ir  <= AUSENTE;
                        presenca_q <= 1'b0;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                default: begin
                    estado_ir  <= AUSENTE;
                    presenca_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_alterna_lampada = cmd_lampada;
    assign bus.cmd_alterna_modo    = cmd_modo;
    assign bus.press_longo         = longo;
    assign bus.presenca            = presenca_q;

endmodule

// File: tb/tb_decodificador_comandos.sv
// Bench for decodificador_comandos: stimulus pushes expected output events
// (kind + cycle) into a queue; a negedge monitor pops on every output event.
module tb_decodificador_comandos;

    localparam int DEB  = 50;
    localparam int SMT  = 5300;
    localparam int HOLD = 3000;

    typedef enum {EV_LAMP, EV_MODO, EV_LONGO_UP, EV_LONGO_DN, EV_PRES_UP, EV_PRES_DN} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
    } ev_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_s  q[$];

    decodificador_comandos_if bus ();

    decodificador_comandos #(
        .DEBOUNCE_T        (DEB),
        .SWITCH_MODE_MIN_T (SMT),
        .PRESENCE_HOLD_T   (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_ev(ev_t k, int c);
        ev_s e;
        e.kind = k;
        e.cyc  = c;
        q.push_back(e);
    endfunction

    task automatic pop_check(ev_t k);
        ev_s e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, queue empty", k.name(), cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s at cycle %0d, need %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    // Monitor: edge-detect every output and score it against the queue
    logic p_longo = 1'b0;
    logic p_pres  = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_alterna_lampada && bus.cmd_alterna_modo) begin
                checks++;
                errors++;
                $display("FAIL both_pulses: lampada=1 modo=1 at cycle %0d, need at most one", cyc);
            end
            if (bus.cmd_alterna_lampada) pop_check(EV_LAMP);
            if (bus.cmd_alterna_modo)    pop_check(EV_MODO);
            if (bus.press_longo && !p_longo) pop_check(EV_LONGO_UP);
            if (!bus.press_longo && p_longo) pop_check(EV_LONGO_DN);
            if (bus.presenca && !p_pres) pop_check(EV_PRES_UP);
            if (!bus.presenca && p_pres) pop_check(EV_PRES_DN);
        end
        p_longo = bus.press_longo;
        p_pres  = bus.presenca;
    end

    task automatic direct_check(string nome, logic got, logic need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s: got %b need %b", nome, got, need);
        end
    endtask

    // Press of h cycles; output timing: released at k+h, pulse at k+h+4,
    // press_longo up at k+SMT+3, down at k+h+3
    task automatic press(int h);
        int k;
        @(posedge clk); #1;
        k = cyc;
        bus.push_button = 1'b1;
        if (h > SMT) begin
            push_ev(EV_LONGO_UP, k + SMT + 3);
            push_ev(EV_LONGO_DN, k + h + 3);
            push_ev(EV_MODO,     k + h + 4);
        end else if (h >= DEB) begin
            push_ev(EV_LAMP, k + h + 4);
        end
        repeat (h) @(posedge clk);
        #1;
        bus.push_button = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int k;
        bus.push_button   = 1'b0;
        bus.infravermelho = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        direct_check("rst_lampada",  bus.cmd_alterna_lampada, 1'b0);
        direct_check("rst_modo",     bus.cmd_alterna_modo,    1'b0);
        direct_check("rst_longo",    bus.press_longo,         1'b0);
        direct_check("rst_presenca", bus.presenca,            1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Boundary: exactly SWITCH_MODE_MIN_T is short, one more is long
        press(SMT);
        press(SMT + 1);

        // Glitches just below debounce, then a minimal valid press
        for (int i = 0; i < 3; i++) press(DEB - 1);
        press(DEB);

        // Very long hold saturates the counter and still reads as long
        press(20000);

        // Reset mid-press: only the 2997 post-reset samples count
        @(posedge clk); #1;
        k = cyc;
        bus.push_button = 1'b1;
        push_ev(EV_LAMP, k + 6004);
        repeat (3000) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2997) @(posedge clk);
        #1 bus.push_button = 1'b0;
        repeat (20) @(posedge clk);

        // IR: 100-cycle presence, falls HOLD+4 cycles after the raw drop
        @(posedge clk); #1;
        k = cyc;
        bus.infravermelho = 1'b1;
        push_ev(EV_PRES_UP, k + DEB + 2);
        push_ev(EV_PRES_DN, k + 100 + HOLD + 4);
        repeat (100) @(posedge clk);
        #1 bus.infravermelho = 1'b0;
        repeat (HOLD + 30) @(posedge clk);

        // IR retrigger at hold cycle 1500: presenca must not drop in between
        @(posedge clk); #1;
        k = cyc;
        bus.infravermelho = 1'b1;
        push_ev(EV_PRES_UP, k + DEB + 2);
        push_ev(EV_PRES_DN, k + 1650 + HOLD + 4);
        repeat (100) @(posedge clk);
        #1 bus.infravermelho = 1'b0;
        repeat (1500) @(posedge clk);
        #1 bus.infravermelho = 1'b1;
        repeat (50) @(posedge clk);
        #1 bus.infravermelho = 1'b0;
        repeat (HOLD + 30) @(posedge clk);

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, need 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
